// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: FSM state encoding and register-index width.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } pipe_state_t;

    typedef logic [4:0] regbits_t;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detect: the load in execute writes a register the decode-stage instruction reads.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic       ex_dREN,
    input  logic [4:0] ex_wsel,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu_hazard
);

    regbits_t wsel;
    assign wsel = ex_wsel;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu_hazard = ex_dREN && (wsel != '0) && ((wsel == id_rs) || (wsel == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: Mealy enables/flushes, RUN/DWAIT/HALT FSM, branch-pending latch.
// Optional stall counter built only when PIPE_STALL_CNT_EN is defined.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_req,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_wsel,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        br_taken,
    input  logic        halt_in,
    output logic        pc_en,
    output logic        fetch_en,
    output logic        dec_en,
    output logic        mem_en,
    output logic        fetch_flush,
    output logic        dec_flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    pipe_state_t state;
    logic        br_pend;
    logic        advance;
    logic        lu_hazard;
    logic        flush_now;

    hazard_detect u_hazard (
        .ex_dREN   (ex_dREN),
        .ex_wsel   (ex_wsel),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .lu_hazard (lu_hazard)
    );

    // Gating with RST keeps every enable low for the whole reset window, not just after the edge.
    assign advance   = !RST && (state != HALT) && ihit && (!mem_req || dhit);
    assign flush_now = (br_taken || br_pend) && advance;

    assign dec_en      = advance;
    assign mem_en      = advance;
    assign fetch_en    = advance && (!lu_hazard || flush_now);
    assign pc_en       = fetch_en;
    assign fetch_flush = flush_now;
    assign dec_flush   = flush_now || (lu_hazard && advance);
    assign halted      = (state == HALT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RUN;
            br_pend <= 1'b0;
        end else begin
            if (halt_in) begin
                state <= HALT;
            end else begin
                case (state)
                    RUN:     if (mem_req && !dhit) state <= DWAIT;
                    DWAIT:   if (dhit)             state <= RUN;
                    HALT:    state <= HALT;
                    default: state <= RUN;
                endcase
            end

            // A taken branch that cannot advance is remembered until the pipe moves.
            if (advance)
                br_pend <= 1'b0;
            else if (br_taken)
                br_pend <= 1'b1;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_q <= '0;
        else if ((state != HALT) && !advance && (stall_q != STALL_CNT_MAX))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, corner-case sequences and a randomized run against a reference model.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, mem_req, ex_dREN, br_taken, halt_in;
    logic [4:0]  ex_wsel, id_rs, id_rt;
    logic        pc_en, fetch_en, dec_en, mem_en, fetch_flush, dec_flush, halted;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: only what is observable matters (halted, pending branch, stall count).
    bit m_halt;
    bit m_pend;
    int m_cnt;

    always #5 CLK = ~CLK;

    pipeline_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .mem_req     (mem_req),
        .ex_dREN     (ex_dREN),
        .ex_wsel     (ex_wsel),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .br_taken    (br_taken),
        .halt_in     (halt_in),
        .pc_en       (pc_en),
        .fetch_en    (fetch_en),
        .dec_en      (dec_en),
        .mem_en      (mem_en),
        .fetch_flush (fetch_flush),
        .dec_flush   (dec_flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic       ihit, dhit, mem_req, ex_dREN;
        logic [4:0] wsel, rs, rt;
        logic       br;
        logic [5:0] exp;   // {pc_en, fetch_en, dec_en, mem_en, fetch_flush, dec_flush}
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs6();
        return {pc_en, fetch_en, dec_en, mem_en, fetch_flush, dec_flush};
    endfunction

    function automatic bit m_advance();
        return !RST && !m_halt && ihit && (!mem_req || dhit);
    endfunction

    function automatic logic [6:0] model_out();
        bit adv, haz, fl, fe;
        adv = m_advance();
        haz = ex_dREN && (ex_wsel != 0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
        fl  = (br_taken || m_pend) && adv;
        fe  = adv && (!haz || fl);
        return {fe, fe, adv, adv, fl, fl || (haz && adv), !RST && m_halt};
    endfunction

    function automatic int model_cnt();
`ifdef PIPE_STALL_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_update();
        bit adv;
        if (RST) begin
            m_halt = 0;
            m_pend = 0;
            m_cnt  = 0;
        end else begin
            adv = m_advance();
            if (!m_halt && !adv && m_cnt < 65535) m_cnt++;
            if (adv) m_pend = 0;
            else if (br_taken) m_pend = 1;
            if (halt_in) m_halt = 1;
        end
    endtask

    // Called 1ns after a rising edge with inputs already driven; compares, then crosses the next edge.
    task automatic step(input string name);
        #1;
        chk({name, " outs"}, {outs6(), halted}, model_out());
        chk({name, " stall_cnt"}, stall_cnt, model_cnt());
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic ih, input logic dh, input logic mr, input logic ld,
                          input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
                          input logic br, input logic hl);
        ihit = ih; dhit = dh; mem_req = mr; ex_dREN = ld;
        ex_wsel = ws; id_rs = rs; id_rt = rt; br_taken = br; halt_in = hl;
    endtask

    initial begin
        m_halt = 0; m_pend = 0; m_cnt = 0;
        RST = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 RST = 1'b1;
        #1;
        chk("reset outs", {outs6(), halted}, 7'b0);
        chk("reset stall_cnt", stall_cnt, 16'd0);
        step("reset");
        RST = 1'b0;

        vecs[0]  = '{1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100};
        vecs[1]  = '{0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000};
        vecs[2]  = '{1, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 6'b001101};
        vecs[3]  = '{1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 6'b111100};
        vecs[4]  = '{1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 6'b001101};
        vecs[5]  = '{1, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0, 6'b111100};
        vecs[6]  = '{1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100};
        vecs[7]  = '{1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000};
        vecs[8]  = '{1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100};
        vecs[9]  = '{1, 0, 0, 1, 5'd9, 5'd9, 5'd2, 1, 6'b111111};
        vecs[10] = '{1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1, 6'b111111};

        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].ihit, vecs[i].dhit, vecs[i].mem_req, vecs[i].ex_dREN,
                   vecs[i].wsel, vecs[i].rs, vecs[i].rt, vecs[i].br, 0);
            #1;
            chk($sformatf("vec%0d", i), outs6(), vecs[i].exp);
            step($sformatf("vec%0d", i));
        end

        // Taken branch waits on ihit for two cycles, then flushes from the pending latch.
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            step("br wait");
            chk("br_pend set", dut.br_pend, 1'b1);
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("br flush", {pc_en, fetch_flush, dec_flush}, 3'b111);
        step("br flush");
        chk("br_pend clear", dut.br_pend, 1'b0);
        step("br after");
        chk("br no reflush", {fetch_flush, dec_flush}, 2'b00);

        // Data wait for three cycles starting from a cleared counter.
        RST = 1'b1;
        step("dwait rst");
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
            #1;
            chk("dwait enables", {pc_en, fetch_en, dec_en, mem_en}, 4'b0000);
            step("dwait");
        end
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("dwait release", {pc_en, fetch_en, dec_en, mem_en}, 4'b1111);
        step("dwait release");
`ifdef PIPE_STALL_CNT_EN
        chk("dwait stall_cnt", stall_cnt, 16'd3);
`else
        chk("dwait stall_cnt", stall_cnt, 16'd0);
`endif

        // One-cycle halt pulse is absorbing until reset.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("halt pulse");
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 1'($urandom_range(0, 1)), 0);
            #1;
            chk("halted", {outs6(), halted}, 7'b0000001);
            step("halted");
        end
        RST = 1'b1;
        #1;
        chk("halt reset", halted, 1'b0);
        step("halt reset");
        RST = 1'b0;

        // Reset landing in DWAIT with a branch pending.
        set_in(1, 0, 1, 0, 0, 0, 0, 1, 0);
        step("pre rst");
        chk("pre rst br_pend", dut.br_pend, 1'b1);
        RST = 1'b1;
        #1;
        chk("mid rst outs", {outs6(), halted}, 7'b0);
        step("mid rst");
        RST = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post rst", outs6(), 6'b111100);
        step("post rst");

        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 39) == 0);
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 59) == 0));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
